multiphase_clock: RTL and testbench

MULTIPHASE_CLOCK -- requirements
Module: multiphase_clock

---
 rtl/multiphase_clock.sv | 181 ++++++++++++++++++
 tb/tb_multiphase_clock.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multiphase_clock.sv
// multiphase_clock
//   Emulated-time clock source. Each time the global next-event time matches
//   this clock's next edge time, the edge fires: the edge time advances by the
//   active period increment (plus optional jitter), the phase index rotates and
//   a one-hot clock enable for the firing phase is issued one cycle later.
//   A new increment is accepted through a one-deep valid/ready slot and only
//   takes effect at a full-cycle boundary, so a cycle never mixes periods.
//
//   Optional build macro: MULTIPHASE_CLOCK_JITTER_EN adds an LFSR jitter term
//   to every edge. Without it the jitter term is zero and no LFSR exists.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   time_next    global next-event time
//   inc_data     new per-phase increment
//   inc_valid    inc_data offered
//   inc_ready    increment slot free
//   time_clock   this clock's next edge time
//   time_eq      edge fires this cycle (combinational)
//   phase        phase index of the next edge
//   cke_out      one-hot clock enables, registered
//   cycle_count  completed full cycles

`ifdef MULTIPHASE_CLOCK_JITTER_EN
// Fibonacci LFSR, shift left, feedback into bit 0. Advances only when en=1.
module lfsr #(
    parameter int          WIDTH = 4,
    parameter logic [31:0] SEED  = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] state
);
    function automatic logic [7:0] taps(input int w);
        case (w)
            2:       taps = 8'b0000_0011;
            3:       taps = 8'b0000_0110;
            5:       taps = 8'b0001_0100;
            6:       taps = 8'b0011_0000;
            7:       taps = 8'b0110_0000;
            8:       taps = 8'b1011_1000;
            default: taps = 8'b0000_1100;
        endcase
    endfunction

    localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(taps(WIDTH));

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             fb;

    always_comb begin
        fb      = ^(state_q & TAP_MASK);
        state_d = state_q;
        if (en) state_d = WIDTH'({state_q, fb});
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= WIDTH'(SEED);
        else     state_q <= state_d;
    end

    assign state = state_q;
endmodule
`endif

module multiphase_clock #(
    parameter int  N_PHASES     = 4,
    parameter int  TIME_WIDTH   = 32,
    parameter int  INC_WIDTH    = 16,
    parameter int  JITTER_WIDTH = 4,
    parameter int  LFSR_INIT    = 1,
    parameter int  INC_RESET    = 100,
    parameter int  CNT_WIDTH    = 16,
    localparam int PH_W         = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TIME_WIDTH-1:0] time_next,
    input  logic [INC_WIDTH-1:0]  inc_data,
    input  logic                  inc_valid,
    output logic                  inc_ready,
    output logic [TIME_WIDTH-1:0] time_clock,
    output logic                  time_eq,
    output logic [PH_W-1:0]       phase,
    output logic [N_PHASES-1:0]   cke_out,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    logic [TIME_WIDTH-1:0]   time_clock_q, time_clock_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [N_PHASES-1:0]     cke_q, cke_d;
    logic [CNT_WIDTH-1:0]    cycle_q, cycle_d;
    logic [INC_WIDTH-1:0]    inc_active_q, inc_active_d;
    logic [INC_WIDTH-1:0]    pend_val_q, pend_val_d;
    logic                    pend_q, pend_d;
    logic [JITTER_WIDTH-1:0] jitter;
    logic                    phase_last;
    logic                    boundary;
    logic                    transfer;

`ifdef MULTIPHASE_CLOCK_JITTER_EN
    lfsr #(
        .WIDTH (JITTER_WIDTH),
        .SEED  (32'(LFSR_INIT))
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (time_eq),
        .state (jitter)
    );
`else
    assign jitter = '0;
`endif

    assign time_eq = (time_next == time_clock_q);

    always_comb begin
        phase_last = (phase_q == PH_W'(N_PHASES - 1));
        boundary   = time_eq & phase_last;
        transfer   = inc_valid & ~pend_q;

        time_clock_d = time_clock_q;
        phase_d      = phase_q;
        cycle_d      = cycle_q;
        if (time_eq) begin
            time_clock_d = time_clock_q + TIME_WIDTH'(inc_active_q) + TIME_WIDTH'(jitter);
            phase_d      = phase_last ? '0 : phase_q + PH_W'(1);
        end
        if (boundary) cycle_d = cycle_q + CNT_WIDTH'(1);

        cke_d = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            cke_d[i] = time_eq && (phase_q == PH_W'(i));
        end

        // The boundary edge itself still uses the old increment because
        // time_clock_d above is built from inc_active_q. Transfers are only
        // possible while the slot is empty, so they never collide with a load.
        inc_active_d = inc_active_q;
        pend_d       = pend_q;
        pend_val_d   = pend_val_q;
        if (boundary && pend_q) begin
            inc_active_d = pend_val_q;
            pend_d       = 1'b0;
        end
        if (transfer) begin
            pend_val_d = inc_data;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_clock_q <= '0;
            phase_q      <= '0;
            cke_q        <= '0;
            cycle_q      <= '0;
            inc_active_q <= INC_WIDTH'(INC_RESET);
            pend_val_q   <= '0;
            pend_q       <= 1'b0;
        end else begin
            time_clock_q <= time_clock_d;
            phase_q      <= phase_d;
            cke_q        <= cke_d;
            cycle_q      <= cycle_d;
            inc_active_q <= inc_active_d;
            pend_val_q   <= pend_val_d;
            pend_q       <= pend_d;
        end
    end

    assign inc_ready   = ~pend_q;
    assign time_clock  = time_clock_q;
    assign phase       = phase_q;
    assign cke_out     = cke_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_multiphase_clock.sv
module tb_multiphase_clock;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] time_next;
    logic [15:0] inc_data;
    logic        inc_valid;
    logic        inc_ready;
    logic [31:0] time_clock;
    logic        time_eq;
    logic [1:0]  phase;
    logic [3:0]  cke_out;
    logic [15:0] cycle_count;

    // Narrow-time instance for the wrap case.
    logic [7:0]  tn8;
    logic        inc_ready8;
    logic [7:0]  tc8;
    logic        teq8;
    logic [1:0]  ph8;
    logic [3:0]  cke8;
    logic [15:0] cc8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiphase_clock u_dut (
        .clk         (clk),
        .rst         (rst),
        .time_next   (time_next),
        .inc_data    (inc_data),
        .inc_valid   (inc_valid),
        .inc_ready   (inc_ready),
        .time_clock  (time_clock),
        .time_eq     (time_eq),
        .phase       (phase),
        .cke_out     (cke_out),
        .cycle_count (cycle_count)
    );

    multiphase_clock #(.TIME_WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .time_next   (tn8),
        .inc_data    (16'd0),
        .inc_valid   (1'b0),
        .inc_ready   (inc_ready8),
        .time_clock  (tc8),
        .time_eq     (teq8),
        .phase       (ph8),
        .cke_out     (cke8),
        .cycle_count (cc8)
    );

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        time_next = 32'hFFFF_FFFF;
        #1;
        chk_eq("time_eq_idle", time_eq, 0);
        tick();
    endtask

    // Fire one edge at time t, then check the post-edge state.
    task automatic fire(input logic [31:0] t, input logic [31:0] exp_tc,
                        input logic [1:0] exp_ph, input logic [3:0] exp_cke);
        time_next = t;
        #1;
        chk_eq("time_eq_fire", time_eq, 1);
        tick();
        time_next = 32'hFFFF_FFFF;
        chk_eq("time_clock", time_clock, exp_tc);
        chk_eq("phase", phase, exp_ph);
        chk_eq("cke_out", cke_out, exp_cke);
    endtask

    initial begin
        rst       = 1'b1;
        time_next = 32'hFFFF_FFFF;
        tn8       = 8'hFF;
        inc_data  = '0;
        inc_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk_eq("rst_time_clock", time_clock, 0);
        chk_eq("rst_phase", phase, 0);
        chk_eq("rst_cke", cke_out, 0);
        chk_eq("rst_cycle", cycle_count, 0);
        chk_eq("rst_ready", inc_ready, 1);
        idle();

        // Basic rotation at the reset increment.
        fire(0,   100, 1, 4'b0001);
        fire(100, 200, 2, 4'b0010);
        fire(200, 300, 3, 4'b0100);
        chk_eq("cycle_before_wrap", cycle_count, 0);
        fire(300, 400, 0, 4'b1000);
        chk_eq("cycle_after_4", cycle_count, 1);
        idle();
        chk_eq("cke_one_cycle", cke_out, 0);
        chk_eq("tc_hold", time_clock, 400);
        fire(400, 500, 1, 4'b0001);

        // Increment 50 offered at phase 1; a held offer of 77 must be ignored.
        inc_data  = 16'd50;
        inc_valid = 1'b1;
        #1;
        chk_eq("ready_before_offer", inc_ready, 1);
        idle();
        chk_eq("ready_fell", inc_ready, 0);
        inc_data = 16'd77;
        fire(500, 600, 2, 4'b0010);
        fire(600, 700, 3, 4'b0100);
        chk_eq("ready_pending", inc_ready, 0);
        fire(700, 800, 0, 4'b1000);
        inc_valid = 1'b0;
        chk_eq("ready_rose", inc_ready, 1);
        chk_eq("cycle_2", cycle_count, 2);
        fire(800, 850, 1, 4'b0001);
        fire(850, 900, 2, 4'b0010);

        // Offer 20 at a boundary with the slot empty; a second offer of 30 refused.
        fire(900, 950, 3, 4'b0100);
        inc_data  = 16'd20;
        inc_valid = 1'b1;
        fire(950, 1000, 0, 4'b1000);
        chk_eq("ready_bnd_offer", inc_ready, 0);
        inc_data = 16'd30;
        idle();
        chk_eq("second_refused", inc_ready, 0);
        inc_valid = 1'b0;
        fire(1000, 1050, 1, 4'b0001);
        fire(1050, 1100, 2, 4'b0010);
        fire(1100, 1150, 3, 4'b0100);
        fire(1150, 1200, 0, 4'b1000);
        chk_eq("cycle_4", cycle_count, 4);
        chk_eq("ready_after_apply", inc_ready, 1);
        fire(1200, 1220, 1, 4'b0001);

        // Reset mid-operation with a pending increment and an edge firing.
        inc_data  = 16'd7;
        inc_valid = 1'b1;
        idle();
        inc_valid = 1'b0;
        chk_eq("pend_before_rst", inc_ready, 0);
        time_next = 1220;
        rst       = 1'b1;
        #1;
        chk_eq("time_eq_at_rst", time_eq, 1);
        tick();
        rst       = 1'b0;
        time_next = 32'hFFFF_FFFF;
        chk_eq("rst2_cke", cke_out, 0);
        chk_eq("rst2_time_clock", time_clock, 0);
        chk_eq("rst2_phase", phase, 0);
        chk_eq("rst2_cycle", cycle_count, 0);
        chk_eq("rst2_ready", inc_ready, 1);
        fire(0,   100, 1, 4'b0001);
        fire(100, 200, 2, 4'b0010);
        fire(200, 300, 3, 4'b0100);
        fire(300, 400, 0, 4'b1000);
        fire(400, 500, 1, 4'b0001);

        // 8-bit time wraps: 200 + 100 = 44.
        chk_eq("tc8_rst", tc8, 0);
        tn8 = 8'd0;
        tick();
        chk_eq("tc8_100", tc8, 100);
        tn8 = 8'd100;
        tick();
        chk_eq("tc8_200", tc8, 200);
        tn8 = 8'd200;
        #1;
        chk_eq("teq8", teq8, 1);
        tick();
        chk_eq("tc8_wrap", tc8, 44);
        chk_eq("ph8", ph8, 3);
        tn8 = 8'hFF;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
